// File: rtl/led_blink_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : led_blink_pkg
// Brief  : Mode encoding, channel state record and sizing helper for the bank.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_t;

  localparam int unsigned CNT_W_MAX = 32;

  // Widest channel record, for debug taps that must cover any CNT_W.
  typedef struct packed {
    mode_t                mode;
    logic [CNT_W_MAX-1:0] half;
    logic [CNT_W_MAX-1:0] cnt;
    logic                 led;
  } chan_state_t;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_blink_bank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : led_blink_bank_if
// Brief  : Valid/ready configuration port of the LED blink bank.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface led_blink_bank_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 28
);
  import led_blink_pkg::*;

  localparam int CH_W = ch_width(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  mode_t            cfg_mode;
  logic [CNT_W-1:0] cfg_half;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_mode,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_half,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/led_blink_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : led_blink_chan
// Brief  : One LED channel: mode FSM, half-period counter, led and tick.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int          CNT_W        = 28,
  parameter int unsigned DEFAULT_HALF = 50000000
) (
  input  wire logic             sys_clk,
  input  wire logic             sys_rst_n,
  input  wire logic             apply,
  input  wire mode_t            apply_mode,
  input  wire logic [CNT_W-1:0] apply_half,
  input  wire logic             sync,
  output logic                  led,
  output logic                  tick
);

  localparam logic [1:0] c_st_off   = 2'd0;
  localparam logic [1:0] c_st_on    = 2'd1;
  localparam logic [1:0] c_st_blink = 2'd2;
  localparam logic [1:0] c_st_pulse = 2'd3;

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_default_half = CNT_W'(DEFAULT_HALF);

  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_tick;

  logic [1:0]       w_apply_st;
  logic [CNT_W-1:0] w_apply_half;
  logic             w_wrap;

  assign w_apply_st   = apply_mode;
  assign w_apply_half = (apply_half == '0) ? c_one : apply_half;
  // r_cnt never passes r_half-1, so the equality test cannot miss a wrap.
  assign w_wrap       = (r_cnt == (r_half - c_one));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= c_st_off;
      r_half <= c_default_half;
      r_cnt  <= '0;
      r_led  <= 1'b0;
      r_tick <= 1'b0;
    end else if (apply) begin
      r_mode <= w_apply_st;
      r_half <= w_apply_half;
      r_cnt  <= '0;
      r_led  <= (w_apply_st == c_st_on) || (w_apply_st == c_st_pulse);
      r_tick <= 1'b0;
    end else if (sync && (r_mode == c_st_blink)) begin
      r_cnt  <= '0;
      r_led  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      case (r_mode)
        c_st_blink: begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_led  <= ~r_led;
            r_tick <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + c_one;
          end
        end
        c_st_pulse: begin
          if (w_wrap) begin
            r_cnt  <= '0;
            r_led  <= 1'b0;
            r_mode <= c_st_off;
            r_tick <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + c_one;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign led  = r_led;
  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/led_blink_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : led_blink_bank
// Brief  : NCH independent LED channels behind a one-entry config register.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module led_blink_bank
  import led_blink_pkg::*;
#(
  parameter int          NCH          = 8,
  parameter int          CNT_W        = 28,
  parameter int unsigned DEFAULT_HALF = 50000000
) (
  input  wire logic           sys_clk,
  input  wire logic           sys_rst_n,
  led_blink_bank_if.slave     cfg,
  input  wire logic           sync_i,
  output wire logic [NCH-1:0] led_o,
  output wire logic [NCH-1:0] tick_o
);

  localparam int CH_W = ch_width(NCH);

  logic             r_ready;
  logic             r_pend_valid;
  logic [CH_W-1:0]  r_pend_ch;
  mode_t            r_pend_mode;
  logic [CNT_W-1:0] r_pend_half;

  logic             w_accept;

  assign w_accept = cfg.cfg_valid && r_ready;

  // A captured entry is always applied on the very next edge, so ready only
  // drops for one cycle and the pending slot can never overflow.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ready      <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_mode  <= MODE_OFF;
      r_pend_half  <= '0;
    end else if (r_pend_valid) begin
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b1;
    end else if (w_accept) begin
      r_pend_valid <= 1'b1;
      r_ready      <= 1'b0;
      r_pend_ch    <= cfg.cfg_ch;
      r_pend_mode  <= cfg.cfg_mode;
      r_pend_half  <= cfg.cfg_half;
    end
  end

  assign cfg.cfg_ready = r_ready;

  // Channel numbers at or above NCH match no decoder and are dropped.
  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_chan
      logic w_apply;
      assign w_apply = r_pend_valid && (r_pend_ch == CH_W'(i));

      led_blink_chan #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
      ) u_chan (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .apply      (w_apply),
        .apply_mode (r_pend_mode),
        .apply_half (r_pend_half),
        .sync       (sync_i),
        .led        (led_o[i]),
        .tick       (tick_o[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_led_blink_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_led_blink_bank
// Brief  : Self-checking bench for led_blink_bank against a timing model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_led_blink_bank;
  import led_blink_pkg::*;

  localparam int NCH      = 4;
  localparam int NCH2     = 3;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 5;

  logic            sys_clk   = 1'b0;
  logic            sys_rst_n = 1'b1;
  logic            sync_i    = 1'b0;
  logic            sync2     = 1'b0;
  wire [NCH-1:0]   led_o;
  wire [NCH-1:0]   tick_o;
  wire [NCH2-1:0]  led2;
  wire [NCH2-1:0]  tick2;

  int checks = 0;
  int errors = 0;

  led_blink_bank_if #(.NCH(NCH),  .CNT_W(CNT_W)) cfg_if ();
  led_blink_bank_if #(.NCH(NCH2), .CNT_W(CNT_W)) cfg2_if ();

  led_blink_bank #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg(cfg_if),
    .sync_i(sync_i), .led_o(led_o), .tick_o(tick_o));

  led_blink_bank #(.NCH(NCH2), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_HALF)) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg(cfg2_if),
    .sync_i(sync2), .led_o(led2), .tick_o(tick2));

  always #5 sys_clk = ~sys_clk;

  // Reference model: each channel keeps its mode, half and the edge index at
  // which its timing origin was set; outputs follow from elapsed edges.
  int n;
  int m_mode [NCH];
  int m_half [NCH];
  int m_t0   [NCH];
  bit m_ready;
  bit m_pend;
  int p_ch, p_mode, p_half;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      n = 0; m_ready = 1'b1; m_pend = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_half[c] = DEF_HALF; m_t0[c] = 0;
      end
    end else begin
      int applied;
      applied = -1;
      n++;
      if (m_pend) begin
        if (p_ch < NCH) begin
          m_mode[p_ch] = p_mode;
          m_half[p_ch] = (p_half == 0) ? 1 : p_half;
          m_t0[p_ch]   = n;
          applied      = p_ch;
        end
        m_pend = 1'b0; m_ready = 1'b1;
      end else if (cfg_if.cfg_valid && m_ready) begin
        p_ch = int'(cfg_if.cfg_ch); p_mode = int'(cfg_if.cfg_mode);
        p_half = int'(cfg_if.cfg_half);
        m_pend = 1'b1; m_ready = 1'b0;
      end
      if (sync_i)
        for (int c = 0; c < NCH; c++)
          if (c != applied && m_mode[c] == 2) m_t0[c] = n;
    end
  end

  function automatic logic [NCH-1:0] exp_led();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      int k;
      k = n - m_t0[c];
      case (m_mode[c])
        1:       v[c] = 1'b1;
        2:       v[c] = ((k / m_half[c]) % 2) == 1;
        3:       v[c] = (k < m_half[c]);
        default: v[c] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_tick();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      int k;
      k = n - m_t0[c];
      case (m_mode[c])
        2:       v[c] = (k > 0) && ((k % m_half[c]) == 0);
        3:       v[c] = (k == m_half[c]);
        default: v[c] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // Drivers: called on a falling edge, return on the falling edge after E0.
  task automatic cfg_send(input int ch, input int mode, input int half);
    int guard;
    guard = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_mode  = mode_t'(mode);
    cfg_if.cfg_half  = CNT_W'(half);
    while (!cfg_if.cfg_ready && guard < 10) begin
      @(negedge sys_clk); guard++;
    end
    if (guard >= 10) begin
      checks++; errors++;
      $display("FAIL cfg_send_timeout ready=%b required=1", cfg_if.cfg_ready);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic cfg2_send(input int ch, input int mode, input int half);
    int guard;
    guard = 0;
    cfg2_if.cfg_valid = 1'b1;
    cfg2_if.cfg_ch    = 2'(ch);
    cfg2_if.cfg_mode  = mode_t'(mode);
    cfg2_if.cfg_half  = CNT_W'(half);
    while (!cfg2_if.cfg_ready && guard < 10) begin
      @(negedge sys_clk); guard++;
    end
    if (guard >= 10) begin
      checks++; errors++;
      $display("FAIL cfg2_send_timeout ready=%b required=1", cfg2_if.cfg_ready);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg2_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      checks++;
      if (led_o !== 4'b0000 || tick_o !== 4'b0000 || cfg_if.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle led=%b tick=%b rdy=%b required 0000 0000 1",
                 led_o, tick_o, cfg_if.cfg_ready);
      end
    end
    cfg_send(0, 1, 1);
    @(negedge sys_clk);
    checks++;
    if (led_o !== 4'b0001) begin
      errors++; $display("FAIL reset_pre_on led=%b required 0001", led_o);
    end
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (led_o !== 4'b0000 || tick_o !== 4'b0000 || cfg_if.cfg_ready !== 1'b1 || led2 !== 3'b000) begin
      errors++;
      $display("FAIL reset_async led=%b tick=%b rdy=%b led2=%b required 0000 0000 1 000",
               led_o, tick_o, cfg_if.cfg_ready, led2);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_blink();
    int ticks;
    ticks = 0;
    cfg_send(1, 2, 3);
    checks++;
    if (cfg_if.cfg_ready !== 1'b0 || led_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL blink_handshake rdy=%b led1=%b required 0 0", cfg_if.cfg_ready, led_o[1]);
    end
    repeat (20) begin
      @(negedge sys_clk);
      checks++;
      if (tick_o[1]) ticks++;
      if (led_o !== exp_led() || tick_o !== exp_tick() || cfg_if.cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL blink led=%b/%b tick=%b/%b rdy=%b/%b (actual/required)",
                 led_o, exp_led(), tick_o, exp_tick(), cfg_if.cfg_ready, m_ready);
      end
    end
    checks++;
    if (ticks !== 6) begin
      errors++; $display("FAIL blink_tick_count got=%0d required=6", ticks);
    end
  endtask

  task automatic test_pulse();
    int highs, ticks;
    highs = 0; ticks = 0;
    cfg_send(2, 3, 4);
    repeat (8) begin
      @(negedge sys_clk);
      checks++;
      if (led_o[2]) highs++;
      if (tick_o[2]) ticks++;
      if (led_o !== exp_led() || tick_o !== exp_tick() || cfg_if.cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL pulse led=%b/%b tick=%b/%b rdy=%b/%b (actual/required)",
                 led_o, exp_led(), tick_o, exp_tick(), cfg_if.cfg_ready, m_ready);
      end
    end
    checks++;
    if (highs !== 4 || ticks !== 1) begin
      errors++; $display("FAIL pulse_window highs=%0d ticks=%0d required 4 1", highs, ticks);
    end
    highs = 0;
    cfg_send(2, 3, 4);
    repeat (2) @(negedge sys_clk);
    cfg_send(2, 3, 4);
    repeat (8) begin
      @(negedge sys_clk);
      checks++;
      if (led_o[2]) highs++;
      if (led_o !== exp_led() || tick_o !== exp_tick()) begin
        errors++;
        $display("FAIL pulse_restart led=%b/%b tick=%b/%b (actual/required)",
                 led_o, exp_led(), tick_o, exp_tick());
      end
    end
    checks++;
    if (highs !== 4) begin
      errors++; $display("FAIL pulse_restart_window highs=%0d required=4", highs);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int idx;
    idx = 0;
    cfg_send(1, 0, 1);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ch = 2'd0;
    cfg_if.cfg_mode = MODE_ON; cfg_if.cfg_half = 8'd1;
    for (int g = 0; g < 10 && idx < 2; g++) begin
      bit will;
      will = cfg_if.cfg_ready;
      @(posedge sys_clk);
      if (will) begin
        acc[idx] = g; idx++;
        #1 cfg_if.cfg_ch = 2'd3;
      end
      @(negedge sys_clk);
    end
    cfg_if.cfg_valid = 1'b0;
    checks++;
    if (idx !== 2 || acc[1] - acc[0] !== 2) begin
      errors++; $display("FAIL b2b_spacing accepts=%0d gap=%0d required 2 2", idx, acc[1] - acc[0]);
    end
    repeat (3) begin
      @(negedge sys_clk);
      checks++;
      if (led_o !== exp_led() || tick_o !== exp_tick() || cfg_if.cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL b2b led=%b/%b tick=%b/%b (actual/required)", led_o, exp_led(), tick_o, exp_tick());
      end
    end
    checks++;
    if (led_o !== 4'b1001) begin
      errors++; $display("FAIL b2b_leds led=%b required 1001", led_o);
    end
    cfg2_send(3, 1, 1);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (led2 !== 3'b000 || cfg2_if.cfg_ready !== 1'b1) begin
      errors++; $display("FAIL out_of_range led2=%b rdy=%b required 000 1", led2, cfg2_if.cfg_ready);
    end
    cfg2_send(2, 1, 1);
    @(negedge sys_clk);
    checks++;
    if (led2 !== 3'b100) begin
      errors++; $display("FAIL in_range_top led2=%b required 100", led2);
    end
  endtask

  task automatic test_sync();
    cfg_send(1, 2, 5);
    repeat (2) @(negedge sys_clk);
    cfg_send(3, 2, 5);
    repeat (4) @(negedge sys_clk);
    sync_i = 1'b1;
    @(negedge sys_clk);
    sync_i = 1'b0;
    checks++;
    if (led_o !== 4'b0001 || tick_o !== 4'b0000) begin
      errors++; $display("FAIL sync_clear led=%b tick=%b required 0001 0000", led_o, tick_o);
    end
    repeat (20) begin
      @(negedge sys_clk);
      checks++;
      if (led_o !== exp_led() || tick_o !== exp_tick() || led_o[1] !== led_o[3] || tick_o[1] !== tick_o[3]) begin
        errors++;
        $display("FAIL sync_align led=%b/%b tick=%b/%b (actual/required)", led_o, exp_led(), tick_o, exp_tick());
      end
    end
    cfg_send(3, 1, 1);
    sync_i = 1'b1;
    @(negedge sys_clk);
    sync_i = 1'b0;
    checks++;
    if (led_o[3] !== 1'b1 || led_o[1] !== 1'b0 || led_o[0] !== 1'b1) begin
      errors++; $display("FAIL sync_vs_apply led=%b required 1x01 pattern led3=1 led1=0 led0=1", led_o);
    end
  endtask

  task automatic test_half_edges();
    int ticks;
    ticks = 0;
    cfg_send(0, 2, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      checks++;
      if (led_o[0] !== k[0] || led_o !== exp_led() || tick_o !== exp_tick()) begin
        errors++;
        $display("FAIL half_zero k=%0d led=%b/%b tick=%b/%b (actual/required)",
                 k, led_o, exp_led(), tick_o, exp_tick());
      end
    end
    cfg_send(0, 2, 255);
    repeat (520) begin
      @(negedge sys_clk);
      checks++;
      if (tick_o[0]) ticks++;
      if (led_o !== exp_led() || tick_o !== exp_tick()) begin
        errors++;
        $display("FAIL half_max led=%b/%b tick=%b/%b (actual/required)", led_o, exp_led(), tick_o, exp_tick());
      end
    end
    checks++;
    if (ticks !== 2) begin
      errors++; $display("FAIL half_max_ticks got=%0d required=2", ticks);
    end
  endtask

  task automatic test_random();
    bit acc_next;
    acc_next = 1'b0;
    repeat (400) begin
      @(negedge sys_clk);
      checks++;
      if (led_o !== exp_led() || tick_o !== exp_tick() || cfg_if.cfg_ready !== m_ready) begin
        errors++;
        $display("FAIL random led=%b/%b tick=%b/%b rdy=%b/%b (actual/required)",
                 led_o, exp_led(), tick_o, exp_tick(), cfg_if.cfg_ready, m_ready);
      end
      if (acc_next) cfg_if.cfg_valid = 1'b0;
      if (!cfg_if.cfg_valid && $urandom_range(0, 2) == 0) begin
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 2'($urandom_range(0, NCH - 1));
        cfg_if.cfg_mode  = mode_t'($urandom_range(0, 3));
        cfg_if.cfg_half  = CNT_W'($urandom_range(0, 9));
      end
      sync_i   = ($urandom_range(0, 15) == 0);
      acc_next = cfg_if.cfg_valid && cfg_if.cfg_ready;
    end
    @(negedge sys_clk);
    cfg_if.cfg_valid = 1'b0;
    sync_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_ch  = '0; cfg_if.cfg_mode  = MODE_OFF; cfg_if.cfg_half  = '0;
    cfg2_if.cfg_valid = 1'b0; cfg2_if.cfg_ch = '0; cfg2_if.cfg_mode = MODE_OFF; cfg2_if.cfg_half = '0;
    test_reset();
    test_blink();
    test_pulse();
    test_back_to_back();
    test_sync();
    test_half_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
